// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// FSM state type and a helper that classifies modes usable by the auto path.
package univ_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Only the single-bit movement modes can be repeated automatically.
  function automatic logic is_auto_mode(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-step next-value logic shared by the manual and automatic paths.
// Load, hold and reserved modes return q unchanged; the top handles load.
module shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin,
  output logic [WIDTH-1:0] res
);

  logic signed [WIDTH-1:0] q_s;

  assign q_s = q;

  // Select the single-bit movement for the requested mode.
  always_comb begin
    res = q;
    unique case (mode)
      MODE_SHL: res = {q[WIDTH-2:0], sin};
      MODE_SHR: res = {sin, q[WIDTH-1:1]};
      MODE_ROL: res = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: res = {q[0], q[WIDTH-1:1]};
      MODE_ASR: res = q_s >>> 1;
      default:  res = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: manual single-cycle operations selected by mode,
// plus an automatic multi-bit shift sequenced by a two-state FSM.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  parameter int               CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             pr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CW-1:0]    amount,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [2:0]       lmode, lmode_nx;
  logic [WIDTH-1:0] q_nx;
  logic             done_nx;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] stepped;

  // While shifting, the latched mode drives both the step and sout.
  assign step_mode = (state == ST_SHIFT) ? lmode : mode;
  assign busy      = (state == ST_SHIFT);
  assign sout      = ((step_mode == MODE_SHL) || (step_mode == MODE_ROL))
                     ? q[WIDTH-1] : q[0];

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q    (q),
    .mode (step_mode),
    .sin  (sin),
    .res  (stepped)
  );

  // Next-state and next-value selection in priority order pr > step > start > manual.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lmode_nx = lmode;
    q_nx     = q;
    done_nx  = 1'b0;
    if (pr) begin
      q_nx     = PRESET_VAL;
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else if (state == ST_SHIFT) begin
      q_nx   = stepped;
      cnt_nx = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state_nx = ST_IDLE;
        done_nx  = 1'b1;
      end
    end else if (start) begin
      if ((amount != '0) && is_auto_mode(mode)) begin
        lmode_nx = mode;
        cnt_nx   = amount;
        state_nx = ST_SHIFT;
      end else begin
        done_nx = 1'b1;
      end
    end else if (en) begin
      q_nx = (mode == MODE_LOAD) ? d : stepped;
    end
  end

  // State register; rs clears everything and wins over all other requests.
  always_ff @(posedge clk) begin
    if (rs) begin
      state <= ST_IDLE;
      cnt   <= '0;
      lmode <= MODE_HOLD;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lmode <= lmode_nx;
      q     <= q_nx;
      done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg with hand-computed expected values.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             rs, pr, en, sin, start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    amount;
  logic [WIDTH-1:0] q;
  logic             sout, busy, done;

  int checks;
  int passed;

  univ_shift_reg #(
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rs     (rs),
    .pr     (pr),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin    (sin),
    .start  (start),
    .amount (amount),
    .q      (q),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    en = 1'b1; mode = 3'd1; d = v;
    tick();
    en = 1'b0; mode = 3'd0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rs = 1'b1; pr = 1'b1; start = 1'b1; en = 1'b1; mode = 3'd2;
    sin = 1'b1; d = 8'hA5; amount = 4'd3;
    tick();
    chk("reset_q", q, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rs = 1'b0; pr = 1'b0; start = 1'b0; en = 1'b0; mode = 3'd0; sin = 1'b0;
    tick();
    chk("reset_hold_q", q, 8'h00);

    // Manual operations
    load(8'h81);
    chk("load_q", q, 8'h81);
    en = 1'b1; mode = 3'd4; tick(); en = 1'b0;
    chk("rol_q", q, 8'h03);
    load(8'h81);
    en = 1'b1; mode = 3'd6; tick(); en = 1'b0;
    chk("asr_q", q, 8'hC0);
    load(8'h81);
    en = 1'b1; mode = 3'd3; sin = 1'b1; tick(); en = 1'b0;
    chk("shr_q", q, 8'hC0);
    load(8'h81);
    en = 1'b1; mode = 3'd5; tick(); en = 1'b0;
    chk("ror_q", q, 8'hC0);
    load(8'h81);
    en = 1'b1; mode = 3'd2; sin = 1'b1; tick(); en = 1'b0; sin = 1'b0;
    chk("shl_q", q, 8'h03);
    mode = 3'd2; #1;
    chk("sout_shl", sout, 0);
    mode = 3'd3; #1;
    chk("sout_shr", sout, 1);
    mode = 3'd1; d = 8'h55; en = 1'b0; tick();
    chk("en_low_hold", q, 8'h03);
    mode = 3'd7; en = 1'b1; tick(); en = 1'b0;
    chk("mode7_hold", q, 8'h03);

    // Automatic rotate right by 3 from 0x96, with start/en/mode noise mid-shift
    load(8'h96);
    start = 1'b1; mode = 3'd5; amount = 4'd3; tick();
    chk("auto_start_q", q, 8'h96);
    chk("auto_busy0", busy, 1);
    start = 1'b1; amount = 4'd1; en = 1'b1; mode = 3'd2; #1;
    chk("auto_sout_latched", sout, 0);
    tick();
    start = 1'b0; en = 1'b0; mode = 3'd0;
    chk("auto_q1", q, 8'h4B);
    chk("auto_busy1", busy, 1);
    chk("auto_done1", done, 0);
    tick();
    chk("auto_q2", q, 8'hA5);
    chk("auto_busy2", busy, 1);
    tick();
    chk("auto_q3", q, 8'hD2);
    chk("auto_busy3", busy, 0);
    chk("auto_done3", done, 1);
    tick();
    chk("auto_done_once", done, 0);
    chk("auto_q_after", q, 8'hD2);

    // Rotate by WIDTH returns the original value
    start = 1'b1; mode = 3'd4; amount = 4'd8; tick(); start = 1'b0; mode = 3'd0;
    repeat (8) tick();
    chk("rot8_q", q, 8'hD2);
    chk("rot8_done", done, 1);
    chk("rot8_busy", busy, 0);

    // Zero amount and non-shift mode complete immediately
    tick();
    start = 1'b1; mode = 3'd4; amount = 4'd0; tick(); start = 1'b0;
    chk("amt0_busy", busy, 0);
    chk("amt0_done", done, 1);
    chk("amt0_q", q, 8'hD2);
    tick();
    chk("amt0_done_clear", done, 0);
    start = 1'b1; mode = 3'd1; amount = 4'd3; d = 8'h11; tick(); start = 1'b0; mode = 3'd0;
    chk("badmode_busy", busy, 0);
    chk("badmode_done", done, 1);
    chk("badmode_q", q, 8'hD2);

    // Preset aborts a shift with no done pulse
    start = 1'b1; mode = 3'd2; amount = 4'd8; sin = 1'b0; tick(); start = 1'b0; mode = 3'd0;
    tick();
    chk("pr_mid_q", q, 8'hA4);
    pr = 1'b1; tick(); pr = 1'b0;
    chk("pr_q", q, 8'hFF);
    chk("pr_busy", busy, 0);
    chk("pr_done", done, 0);
    tick();
    chk("pr_done_after", done, 0);
    chk("pr_q_after", q, 8'hFF);

    // Reset mid-shift
    start = 1'b1; mode = 3'd3; amount = 4'd5; sin = 1'b0; tick(); start = 1'b0; mode = 3'd0;
    tick(); tick();
    chk("rs_mid_q", q, 8'h3F);
    chk("rs_mid_busy", busy, 1);
    rs = 1'b1; tick(); rs = 1'b0;
    chk("rs_q", q, 8'h00);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    tick();
    chk("rs_done_after", done, 0);
    chk("rs_busy_after", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
